mult_share_arbiter: RTL and testbench

Round-robin scheduler that shares one sequential multiplier among NUM_REQ requesters. It accepts one operand pair at a time through per-requester valid/ready handshakes and issues it to the multiplier with a single-cycle start pulse. It then waits for the multiplier's done pulse, or for a watchdog timeout, and returns the product to the granted requester through a held response handshake. It sits between client blocks and the shift-add multiplier core, which has a `valid`/`done`/`result` interface.

---
 rtl/mult_share_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_mult_share_arbiter.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin front end that shares one sequential
// multiplier among NUM_REQ requesters, with a watchdog on the result.
module mult_share_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [2*DATA_WIDTH-1:0]       rsp_result,
    output logic                          rsp_error,
    input  logic                          rsp_ready,
    output logic                          mul_valid,
    output logic [DATA_WIDTH-1:0]         mul_a,
    output logic [DATA_WIDTH-1:0]         mul_b,
    input  logic                          mul_done,
    input  logic [2*DATA_WIDTH-1:0]       mul_result,
    output logic                          busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam int PW = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e state_q, state_d;

    logic [IW-1:0]         ptr_q, ptr_d;
    logic [IW-1:0]         gnt_q, gnt_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]         res_q, res_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;

    logic                  arb_hit;
    logic [IW-1:0]         arb_idx;
    logic [IW:0]           arb_pos;
    logic                  timeout_hit;
    logic [IW-1:0]         gnt_next;

    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
    assign gnt_next    = (gnt_q == IW'(NUM_REQ - 1)) ? '0 : gnt_q + IW'(1);

    // First valid requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        arb_pos = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            arb_pos = {1'b0, ptr_q} + (IW+1)'(i);
            if (arb_pos >= (IW+1)'(NUM_REQ)) begin
                arb_pos = arb_pos - (IW+1)'(NUM_REQ);
            end
            if (!arb_hit && req_valid[arb_pos[IW-1:0]]) begin
                arb_hit = 1'b1;
                arb_idx = arb_pos[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (arb_hit) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mul_done || timeout_hit) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        gnt_d = gnt_q;
        cnt_d = cnt_q;
        res_d = res_q;
        err_d = err_q;
        a_d   = a_q;
        b_d   = b_q;
        unique case (state_q)
            S_IDLE: begin
                if (arb_hit) begin
                    gnt_d = arb_idx;
                    a_d   = req_a[arb_idx*DATA_WIDTH +: DATA_WIDTH];
                    b_d   = req_b[arb_idx*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            S_ISSUE: begin
                cnt_d = '0;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                // A done pulse on the last watchdog cycle still wins.
                if (mul_done) begin
                    res_d = mul_result;
                    err_d = 1'b0;
                end else if (timeout_hit) begin
                    res_d = '0;
                    err_d = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    ptr_d = gnt_next;
                    a_d   = '0;
                    b_d   = '0;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            gnt_q <= '0;
            cnt_q <= '0;
            res_q <= '0;
            err_q <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            ptr_q <= ptr_d;
            gnt_q <= gnt_d;
            cnt_q <= cnt_d;
            res_q <= res_d;
            err_q <= err_d;
            a_q   <= a_d;
            b_q   <= b_d;
        end
    end

    always_comb begin
        req_ready  = '0;
        rsp_valid  = '0;
        rsp_result = '0;
        rsp_error  = 1'b0;
        mul_valid  = 1'b0;
        busy       = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (arb_hit) begin
                    req_ready[arb_idx] = 1'b1;
                end
            end
            S_ISSUE: begin
                mul_valid = 1'b1;
            end
            S_WAIT: begin
                mul_valid = 1'b0;
            end
            S_RESP: begin
                rsp_valid[gnt_q] = 1'b1;
                rsp_result       = res_q;
                rsp_error        = err_q;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign mul_a = a_q;
    assign mul_b = b_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed bench with a behavioural multiplier of
// programmable latency (0 = never completes).
module tb_mult_share_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_a;
    logic [N*DW-1:0] req_b;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [2*DW-1:0] rsp_result;
    logic            rsp_error;
    logic            rsp_ready;
    logic            mul_valid;
    logic [DW-1:0]   mul_a;
    logic [DW-1:0]   mul_b;
    logic            mul_done;
    logic [2*DW-1:0] mul_result;
    logic            busy;

    logic            done_m;
    logic            done_x;
    int              mul_lat;
    int              mcnt;
    logic [2*DW-1:0] mprod;

    int checks = 0;
    int errors = 0;

    assign mul_done = done_m | done_x;

    always #5 clk = ~clk;

    mult_share_arbiter #(
        .NUM_REQ   (N),
        .DATA_WIDTH(DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_result(rsp_result),
        .rsp_error (rsp_error),
        .rsp_ready (rsp_ready),
        .mul_valid (mul_valid),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_done  (mul_done),
        .mul_result(mul_result),
        .busy      (busy)
    );

    // Multiplier stand-in: done in cycle 1+L when started in cycle 1.
    initial begin
        done_m     = 1'b0;
        mul_result = '0;
        mcnt       = 0;
        mprod      = '0;
        forever begin
            @(posedge clk);
            #1;
            done_m = 1'b0;
            if (rst) begin
                mcnt = 0;
            end else if (mul_valid) begin
                mcnt  = mul_lat;
                mprod = 16'(mul_a) * 16'(mul_b);
            end else if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) begin
                    done_m     = 1'b1;
                    mul_result = mprod;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [DW-1:0] a,
                          input logic [DW-1:0] b);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_result, rsp_error, mul_valid,
             mul_a, mul_b, busy} !== '0) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b res=%h err=%b mv=%b a=%h b=%h busy=%b, expected all zero",
                     req_ready, rsp_valid, rsp_result, rsp_error,
                     mul_valid, mul_a, mul_b, busy);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single();
        int bad;
        mul_lat = 10;
        set_op(2, 8'hFF, 8'hFF);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_accept: req_ready=%b expected 0100", req_ready);
        end
        tick();
        req_valid = '0;
        #1;
        checks++;
        if (mul_valid !== 1'b1 || busy !== 1'b1 || mul_a !== 8'hFF ||
            mul_b !== 8'hFF) begin
            errors++;
            $display("FAIL single_issue: mv=%b busy=%b a=%h b=%h expected 1 1 ff ff",
                     mul_valid, busy, mul_a, mul_b);
        end
        bad = 0;
        for (int c = 2; c <= 11; c++) begin
            tick();
            #1;
            if (mul_valid !== 1'b0 || rsp_valid !== '0 ||
                mul_a !== 8'hFF || mul_b !== 8'hFF || busy !== 1'b1) begin
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL single_wait: %0d bad cycles, expected 0", bad);
        end
        tick();
        #1;
        checks++;
        if (rsp_valid !== 4'b0100 || rsp_result !== 16'hFE01 ||
            rsp_error !== 1'b0 || mul_a !== 8'hFF) begin
            errors++;
            $display("FAIL single_rsp: vld=%b res=%h err=%b a=%h expected 0100 fe01 0 ff",
                     rsp_valid, rsp_result, rsp_error, mul_a);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== '0 || busy !== 1'b0 || mul_a !== 8'h00) begin
            errors++;
            $display("FAIL single_done: vld=%b busy=%b a=%h expected 0000 0 00",
                     rsp_valid, busy, mul_a);
        end
    endtask

    task automatic test_round_robin();
        int              n;
        int              eg[5];
        logic [2*DW-1:0] er[5];
        logic [N-1:0]    oh;
        eg = '{0, 1, 2, 3, 0};
        er = '{16'd15, 16'd63, 16'd0, 16'd400, 16'd15};
        apply_reset();
        set_op(0, 8'd3, 8'd5);
        set_op(1, 8'd7, 8'd9);
        set_op(2, 8'd0, 8'h11);
        set_op(3, 8'd200, 8'd2);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << eg[k];
            n  = 0;
            #1;
            while (req_ready === '0 && n < 50) begin
                tick();
                #1;
                n++;
            end
            checks++;
            if (req_ready !== oh) begin
                errors++;
                $display("FAIL rr_grant[%0d]: req_ready=%b expected %b",
                         k, req_ready, oh);
            end
            n = 0;
            while (rsp_valid === '0 && n < 60) begin
                tick();
                #1;
                n++;
            end
            checks++;
            if (rsp_valid !== oh || rsp_result !== er[k] ||
                rsp_error !== 1'b0) begin
                errors++;
                $display("FAIL rr_rsp[%0d]: vld=%b res=%0d err=%b expected %b %0d 0",
                         k, rsp_valid, rsp_result, rsp_error, oh, er[k]);
            end
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
        req_valid = '0;
    endtask

    task automatic test_back_to_back();
        int n;
        set_op(1, 8'd12, 8'd12);
        set_op(3, 8'd5, 8'd6);
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_accept: req_ready=%b expected 0010", req_ready);
        end
        tick();
        req_valid = 4'b1000;
        n = 0;
        #1;
        while (rsp_valid === '0 && n < 60) begin
            tick();
            #1;
            n++;
        end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (rsp_valid !== 4'b0010 || rsp_result !== 16'd144 ||
                rsp_error !== 1'b0 || req_ready !== '0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: vld=%b res=%0d err=%b rdy=%b expected 0010 144 0 0000",
                         i, rsp_valid, rsp_result, rsp_error, req_ready);
            end
            tick();
            #1;
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== '0 || req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL bp_next: busy=%b vld=%b rdy=%b expected 0 0000 1000",
                     busy, rsp_valid, req_ready);
        end
        tick();
        req_valid = '0;
        n = 0;
        #1;
        while (rsp_valid === '0 && n < 60) begin
            tick();
            #1;
            n++;
        end
        checks++;
        if (rsp_valid !== 4'b1000 || rsp_result !== 16'd30) begin
            errors++;
            $display("FAIL bp_second: vld=%b res=%0d expected 1000 30",
                     rsp_valid, rsp_result);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        mul_lat = 0;
        set_op(1, 8'd9, 8'd9);
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL to_accept: req_ready=%b expected 0010", req_ready);
        end
        tick();
        req_valid = '0;
        n = 1;
        #1;
        while (rsp_valid === '0 && n < 100) begin
            tick();
            #1;
            n++;
        end
        checks++;
        if (n != TO + 2 || rsp_valid !== 4'b0010 || rsp_error !== 1'b1 ||
            rsp_result !== '0) begin
            errors++;
            $display("FAIL to_rsp: cycle=%0d vld=%b err=%b res=%h expected 34 0010 1 0000",
                     n, rsp_valid, rsp_error, rsp_result);
        end
        done_x = 1'b1;
        tick();
        done_x = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 4'b0010 || rsp_error !== 1'b1 ||
            rsp_result !== '0) begin
            errors++;
            $display("FAIL to_late_done: vld=%b err=%b res=%h expected 0010 1 0000",
                     rsp_valid, rsp_error, rsp_result);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        done_x    = 1'b1;
        tick();
        done_x = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== '0 || mul_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_stray_done: busy=%b vld=%b mv=%b expected 0 0000 0",
                     busy, rsp_valid, mul_valid);
        end
        tick();
        tick();
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== '0) begin
            errors++;
            $display("FAIL idle_quiet: busy=%b vld=%b expected 0 0000",
                     busy, rsp_valid);
        end
    endtask

    task automatic test_boundary();
        int n;
        mul_lat = TO;
        set_op(1, 8'd1, 8'd1);
        set_op(2, 8'd13, 8'd11);
        req_valid = 4'b0110;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL ptr_after_error: req_ready=%b expected 0100", req_ready);
        end
        tick();
        req_valid = '0;
        n = 1;
        #1;
        while (rsp_valid === '0 && n < 100) begin
            tick();
            #1;
            n++;
        end
        checks++;
        if (n != TO + 2 || rsp_valid !== 4'b0100 || rsp_error !== 1'b0 ||
            rsp_result !== 16'd143) begin
            errors++;
            $display("FAIL edge_done: cycle=%0d vld=%b err=%b res=%0d expected 34 0100 0 143",
                     n, rsp_valid, rsp_error, rsp_result);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        mul_lat = 10;
        set_op(1, 8'd4, 8'd4);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        tick();
        tick();
        tick();
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_result, rsp_error, mul_valid,
             mul_a, mul_b, busy} !== '0) begin
            errors++;
            $display("FAIL mid_reset: rdy=%b vld=%b res=%h err=%b mv=%b a=%h b=%h busy=%b, expected all zero",
                     req_ready, rsp_valid, rsp_result, rsp_error,
                     mul_valid, mul_a, mul_b, busy);
        end
        tick();
        tick();
        rst = 1'b0;
        set_op(0, 8'd3, 8'd5);
        set_op(3, 8'd2, 8'd2);
        req_valid = 4'b1001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL mid_ptr: req_ready=%b expected 0001", req_ready);
        end
        tick();
        req_valid = '0;
        n = 0;
        #1;
        while (rsp_valid === '0 && n < 60) begin
            tick();
            #1;
            n++;
        end
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_result !== 16'd15 ||
            rsp_error !== 1'b0) begin
            errors++;
            $display("FAIL mid_after: vld=%b res=%0d err=%b expected 0001 15 0",
                     rsp_valid, rsp_result, rsp_error);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        done_x    = 1'b0;
        mul_lat   = 10;
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_timeout();
        test_boundary();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
